// File: rtl/sr_alu_arb_pkg.sv
// sr_alu_arb_pkg: request/response payload types for the shared-ALU arbiter
package sr_alu_arb_pkg;
  typedef struct packed {
    logic [2:0]  oper;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } alu_req_t;
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ov;
  } alu_rsp_t;
endpackage

// File: rtl/sr_alu_arb_if.sv
// sr_alu_arb_if: request channels, tagged response channel and sticky-flag controls
interface sr_alu_arb_if #(parameter int N_REQ = 4);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][2:0]  req_oper;
  logic [N_REQ-1:0][31:0] req_src_a;
  logic [N_REQ-1:0][31:0] req_src_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [31:0]            rsp_result;
  logic                   rsp_zero;
  logic                   rsp_ov;
  logic [N_REQ-1:0]       ov_sticky;
  logic [N_REQ-1:0]       ov_clear;
  modport master (
    output req_valid, req_oper, req_src_a, req_src_b, rsp_ready, ov_clear,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ov, ov_sticky
  );
  modport slave (
    input  req_valid, req_oper, req_src_a, req_src_b, rsp_ready, ov_clear,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ov, ov_sticky
  );
endinterface

// File: rtl/sr_alu.sv
// sr_alu: scalar ALU plus packed-SIMD saturating byte shift (KSLL8)
`include "sr_cpu.svh"
module sr_alu (
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  oper,
  output logic [31:0] result,
  output logic        zero,
  output logic        ov
);
  logic [31:0] ks;
  logic [15:0] w;
  logic        sat;
  // ov comes from the KSLL8 datapath regardless of oper; callers must mask it
  always_comb begin
    ks  = '0;
    ov  = 1'b0;
    w   = '0;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w   = {{8{src_a[8*k+7]}}, src_a[8*k +: 8]} << src_b[2:0];
      sat = !((&w[15:7]) || !(|w[15:7]));
      ks[8*k +: 8] = sat ? (w[15] ? 8'h80 : 8'h7F) : w[7:0];
      ov  = ov | sat;
    end
  end
  always_comb begin
    case (oper)
      `ALU_OR:    result = src_a | src_b;
      `ALU_SRL:   result = src_a >> src_b[4:0];
      `ALU_SLTU:  result = {31'b0, src_a < src_b};
      `ALU_SUB:   result = src_a - src_b;
      `ALU_KSLL8: result = ks;
      default:    result = src_a + src_b;
    endcase
  end
  assign zero = result == 32'b0;
endmodule

// File: rtl/sr_cpu.svh
// sr_cpu: shared ALU opcode encodings for the core and its helpers
`ifndef SR_CPU_SVH
`define SR_CPU_SVH
`define ALU_ADD   3'b000
`define ALU_OR    3'b001
`define ALU_SRL   3'b010
`define ALU_SLTU  3'b011
`define ALU_SUB   3'b100
`define ALU_KSLL8 3'b101
`endif

// File: rtl/sr_rr_arbiter.sv
// sr_rr_arbiter: round-robin grant starting at a pointer that moves past each accepted winner
module sr_rr_arbiter #(parameter int N_REQ = 4) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int ID_W = $clog2(N_REQ);
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] masked, pick;
  // requests at or above the pointer win; otherwise wrap to the lowest request
  always_comb begin
    masked   = req & ~((N_REQ'(1) << ptr) - N_REQ'(1));
    pick     = (|masked) ? masked : req;
    grant    = pick & (~pick + N_REQ'(1));
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) grant_id = ID_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  end
endmodule

// File: rtl/sr_alu_arbiter.sv
// sr_alu_arbiter: shares one sr_alu among N_REQ requesters with a registered, id-tagged response
`include "sr_cpu.svh"
module sr_alu_arbiter
  import sr_alu_arb_pkg::*;
#(parameter int N_REQ = 4) (
  input logic         clk,
  input logic         rst,
  sr_alu_arb_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] grant, ready, sticky;
  logic [ID_W-1:0]  grant_id, rsp_id;
  logic             can_acc, accept, rsp_valid, alu_zero, alu_ov;
  logic [31:0]      alu_res;
  alu_req_t         sel;
  alu_rsp_t         nxt, rsp;
  assign can_acc = !rsp_valid || bus.rsp_ready;
  assign ready   = rst ? '0 : grant & {N_REQ{can_acc}};
  assign accept  = |ready;
  sr_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk), .rst(rst), .req(bus.req_valid), .advance(accept),
    .grant(grant), .grant_id(grant_id)
  );
  assign sel = '{oper: bus.req_oper[grant_id], src_a: bus.req_src_a[grant_id], src_b: bus.req_src_b[grant_id]};
  sr_alu u_alu (
    .src_a(sel.src_a), .src_b(sel.src_b), .oper(sel.oper),
    .result(alu_res), .zero(alu_zero), .ov(alu_ov)
  );
  // the ALU ov is meaningless outside KSLL8
  assign nxt = '{result: alu_res, zero: alu_zero, ov: (sel.oper == `ALU_KSLL8) && alu_ov};
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp       <= '0;
      sticky    <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp       <= nxt;
      end else if (bus.rsp_ready) rsp_valid <= 1'b0;
      sticky <= (sticky & ~bus.ov_clear) | (ready & {N_REQ{nxt.ov}});
    end
  end
  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp.result;
  assign bus.rsp_zero   = rsp.zero;
  assign bus.rsp_ov     = rsp.ov;
  assign bus.ov_sticky  = sticky;
endmodule
